// File: rtl/ps2_kbd_rx_if.sv
// Scancode stream from the PS/2 receiver to the scancode-to-ASCII stage.
// Handshake: an entry transfers on any clk edge where code_valid && code_ready; the producer holds data/flags steady while code_valid is high and no transfer occurs.
interface ps2_kbd_rx_if;
   logic [7:0] code_data;
   logic       code_ext;
   logic       code_break;
   logic       code_valid;
   logic       code_ready;

   modport master (
      output code_data,
      output code_ext,
      output code_break,
      output code_valid,
      input  code_ready
   );

   modport slave (
      input  code_data,
      input  code_ext,
      input  code_break,
      input  code_valid,
      output code_ready
   );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, decodes 11-bit frames,
// folds E0/F0 prefixes into flags and queues scancodes in a small FIFO.
module ps2_kbd_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 2500,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               i_kbd_clk,
   input  logic               i_kbd_data,
   ps2_kbd_rx_if.master       o_code,
   output logic               o_frame_err,
   output logic               o_overflow,
   output logic [1:0]         o_dbg_state
);

   localparam int FLT_W = $clog2(FILTER_LEN + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   logic             r_clk_s1, r_clk_s2;
   logic             r_dat_s1, r_dat_s2;
   logic             r_clk_filt;
   logic [FLT_W-1:0] r_flt_cnt;

   state_t           r_state;
   logic [7:0]       r_shift;
   logic [2:0]       r_bit_cnt;
   logic             r_parity;
   logic [TO_W-1:0]  r_to_cnt;
   logic             r_ext;
   logic             r_brk;
   logic             r_frame_err;

   logic [9:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_overflow;

   logic             w_flt_hit;
   logic             w_fall;
   logic             w_good;
   logic             w_push;
   logic             w_timeout;
   logic             w_full;
   logic             w_valid;
   logic             w_pop;
   logic             w_wr;
   logic [9:0]       w_head;

   // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
   assign w_flt_hit = (r_clk_s2 != r_clk_filt) && (r_flt_cnt == FLT_W'(FILTER_LEN - 1));
   assign w_fall    = w_flt_hit && r_clk_filt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_clk_filt <= 1'b1;
         r_flt_cnt  <= '0;
      end else begin
         r_clk_s1 <= i_kbd_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= i_kbd_data;
         r_dat_s2 <= r_dat_s1;
         if (w_flt_hit) begin
            r_clk_filt <= r_clk_s2;
            r_flt_cnt  <= '0;
         end else if (r_clk_s2 != r_clk_filt) begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
         end else begin
            r_flt_cnt <= '0;
         end
      end
   end

   // Odd parity: data ones plus the parity bit must be odd, and stop must be high.
   assign w_good    = (r_state == S_STOP) && w_fall && r_dat_s2 && (^{r_shift, r_parity});
   assign w_push    = w_good && (r_shift != 8'hE0) && (r_shift != 8'hF0);
   assign w_timeout = (r_state != S_IDLE) && !w_fall &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_parity    <= 1'b0;
         r_to_cnt    <= '0;
         r_ext       <= 1'b0;
         r_brk       <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (w_timeout) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_frame_err <= 1'b1;
         end else begin
            if (w_fall || (r_state == S_IDLE)) r_to_cnt <= '0;
            else                               r_to_cnt <= r_to_cnt + 1'b1;
            if (w_fall) begin
               case (r_state)
                  S_IDLE: begin
                     if (!r_dat_s2) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                     end
                  end
                  S_DATA: begin
                     r_shift   <= {r_dat_s2, r_shift[7:1]};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                  end
                  S_PARITY: begin
                     r_parity <= r_dat_s2;
                     r_state  <= S_STOP;
                  end
                  S_STOP: begin
                     r_state <= S_IDLE;
                     if (!w_good) begin
                        r_frame_err <= 1'b1;
                        r_ext       <= 1'b0;
                        r_brk       <= 1'b0;
                     end else if (r_shift == 8'hE0) begin
                        r_ext <= 1'b1;
                     end else if (r_shift == 8'hF0) begin
                        r_brk <= 1'b1;
                     end else begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                     end
                  end
                  default: r_state <= S_IDLE;
               endcase
            end
         end
      end
   end

   assign w_full  = (r_count == (AW + 1)'(FIFO_DEPTH));
   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid && o_code.code_ready;
   assign w_wr    = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {r_ext, r_brk, r_shift};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_push && w_full && !w_pop;
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // Gate the head with valid so an empty FIFO never exposes stale or unwritten entries.
   assign w_head              = w_valid ? r_mem[r_rd_ptr] : 10'd0;
   assign o_code.code_data    = w_head[7:0];
   assign o_code.code_break   = w_head[8];
   assign o_code.code_ext     = w_head[9];
   assign o_code.code_valid   = w_valid;
   assign o_frame_err         = r_frame_err;
   assign o_overflow          = r_overflow;
   assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: bit-banged PS/2 frames, a pop monitor and an expected-entry queue.
module tb_ps2_kbd_rx;
   localparam int FILTER_LEN     = 8;
   localparam int TIMEOUT_CYCLES = 2500;
   localparam int FIFO_DEPTH     = 4;
   localparam int HALF           = 20;
   // Pin fall to filtered edge: 2 sync stages plus FILTER_LEN samples; the result registers one clk later.
   localparam int EDGE_LAT       = 2 + FILTER_LEN;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       kbd_clk = 1'b1;
   logic       kbd_data = 1'b1;
   logic       frame_err;
   logic       overflow;
   logic [1:0] dbg_state;

   ps2_kbd_rx_if u_if ();

   ps2_kbd_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .FIFO_DEPTH     (FIFO_DEPTH)
   ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .i_kbd_clk   (kbd_clk),
      .i_kbd_data  (kbd_data),
      .o_code      (u_if),
      .o_frame_err (frame_err),
      .o_overflow  (overflow),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   int         cyc = 0;
   int         last_fall = 0;
   int         err_cnt = 0;
   int         ovf_cnt = 0;
   int         err_cyc = 0;
   int         valid_rise_cyc = 0;
   int         valid_hi_cnt = 0;
   logic       prev_valid = 1'b0;
   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_if.code_valid && u_if.code_ready)
         got_q.push_back({u_if.code_ext, u_if.code_break, u_if.code_data});
      if (frame_err) begin
         err_cnt++;
         err_cyc = cyc;
      end
      if (overflow) ovf_cnt++;
      if (u_if.code_valid) valid_hi_cnt++;
      if (u_if.code_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = u_if.code_valid;
   end

   task automatic set_ready(input logic r);
      @(posedge clk);
      #1 u_if.code_ready = r;
   endtask

   task automatic drive_bit(input logic b);
      @(negedge clk);
      kbd_data = b;
      repeat (HALF) @(negedge clk);
      kbd_clk   = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      kbd_clk = 1'b1;
   endtask

   task automatic glitch(input logic [1:0] exp_st, input string tag);
      repeat (5) @(negedge clk);
      kbd_clk = 1'b0;
      repeat (3) @(negedge clk);
      kbd_clk = 1'b1;
      repeat (FILTER_LEN + 4) @(negedge clk);
      check(tag, 32'(dbg_state), 32'(exp_st));
   endtask

   // glitch_after >= 0 injects a short kbd_clk low pulse after that bit; the FSM must still be in DATA.
   task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits,
                            input int glitch_after);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         drive_bit(bits[i]);
         if (i == glitch_after) glitch(2'd1, "glitch_mid_frame");
      end
      repeat (HALF) @(negedge clk);
      kbd_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      send_bits(b, bad_par, 11, -1);
   endtask

   task automatic compare_q(input string tag);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() != 0 && got_q.size() != 0)
         check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      got_q.delete();
      exp_q.delete();
   endtask

   int e0, o0, v0;

   initial begin
      u_if.code_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(u_if.code_valid), 32'd0);
      check("rst_data",  32'(u_if.code_data),  32'd0);
      check("rst_ext",   32'(u_if.code_ext),   32'd0);
      check("rst_break", 32'(u_if.code_break), 32'd0);
      check("rst_ferr",  32'(frame_err),       32'd0);
      check("rst_ovf",   32'(overflow),        32'd0);
      check("rst_state", 32'(dbg_state),       32'd0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      // Good 0x1C: parity bit 0, valid for one cycle EDGE_LAT after the stop-bit fall.
      v0 = valid_hi_cnt;
      send_frame(8'h1C, 1'b0);
      exp_q.push_back({2'b00, 8'h1C});
      check("latency", 32'(valid_rise_cyc - last_fall), 32'(EDGE_LAT));
      check("valid_one_cycle", 32'(valid_hi_cnt - v0), 32'd1);
      compare_q("good_1c");

      // E0 F0 6B folds into one flagged entry; the next 6B has both flags clear.
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h6B, 1'b0);
      send_frame(8'h6B, 1'b0);
      exp_q.push_back({2'b11, 8'h6B});
      exp_q.push_back({2'b00, 8'h6B});
      compare_q("prefix");

      e0 = err_cnt;
      v0 = valid_hi_cnt;
      send_frame(8'h1C, 1'b1);
      check("bad_parity_err", 32'(err_cnt - e0), 32'd1);
      check("bad_parity_novalid", 32'(valid_hi_cnt - v0), 32'd0);

      // A parity error after F0 must drop the break flag.
      e0 = err_cnt;
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b1);
      send_frame(8'h1C, 1'b0);
      exp_q.push_back({2'b00, 8'h1C});
      check("flag_clear_err", 32'(err_cnt - e0), 32'd1);
      compare_q("flag_clear");

      set_ready(1'b0);
      o0 = ovf_cnt;
      send_frame(8'h15, 1'b0);
      send_frame(8'h16, 1'b0);
      send_frame(8'h1E, 1'b0);
      send_frame(8'h26, 1'b0);
      check("full_no_ovf", 32'(ovf_cnt - o0), 32'd0);
      send_frame(8'h25, 1'b0);
      check("overflow_once", 32'(ovf_cnt - o0), 32'd1);
      check("held_head", 32'(u_if.code_data), 32'h15);
      check("held_valid", 32'(u_if.code_valid), 32'd1);
      set_ready(1'b1);
      repeat (10) @(negedge clk);
      exp_q.push_back({2'b00, 8'h15});
      exp_q.push_back({2'b00, 8'h16});
      exp_q.push_back({2'b00, 8'h1E});
      exp_q.push_back({2'b00, 8'h26});
      compare_q("drain");
      check("drain_empty", 32'(u_if.code_valid), 32'd0);

      e0 = err_cnt;
      glitch(2'd0, "glitch_idle");
      send_bits(8'h29, 1'b0, 11, 3);
      send_frame(8'h29, 1'b0);
      exp_q.push_back({2'b00, 8'h29});
      exp_q.push_back({2'b00, 8'h29});
      check("glitch_no_err", 32'(err_cnt - e0), 32'd0);
      compare_q("glitch");

      // Start + 4 data bits, then silence: timeout TIMEOUT_CYCLES after the filtered edge.
      e0 = err_cnt;
      send_bits(8'h0F, 1'b0, 5, -1);
      repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
      check("timeout_err", 32'(err_cnt - e0), 32'd1);
      check("timeout_time", 32'(err_cyc - last_fall), 32'(EDGE_LAT + TIMEOUT_CYCLES));
      check("timeout_idle", 32'(dbg_state), 32'd0);
      send_frame(8'h5A, 1'b0);
      exp_q.push_back({2'b00, 8'h5A});
      compare_q("after_timeout");

      // Queue a flagged entry, leave an F0 pending and a partial frame, then reset.
      set_ready(1'b0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check("pre_reset_valid", 32'(u_if.code_valid), 32'd1);
      check("pre_reset_ext", 32'(u_if.code_ext), 32'd1);
      send_frame(8'hF0, 1'b0);
      send_bits(8'h33, 1'b0, 4, -1);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_reset_valid", 32'(u_if.code_valid), 32'd0);
      check("post_reset_data", 32'(u_if.code_data), 32'd0);
      check("post_reset_ext", 32'(u_if.code_ext), 32'd0);
      check("post_reset_state", 32'(dbg_state), 32'd0);
      set_ready(1'b1);
      send_frame(8'h33, 1'b0);
      exp_q.push_back({2'b00, 8'h33});
      compare_q("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
